// File: rtl/hex_display_arbiter_if.sv
// Display arbitration bus: three requesters, one shared six-digit display.
// Requesters drive REQ/ADV/DATA; the arbiter returns GNT and the segments.
interface hex_display_arbiter_if;
  logic [0:2]  REQ;
  logic        ADV;
  logic [0:23] DATA0;
  logic [0:23] DATA1;
  logic [0:23] DATA2;
  logic [0:2]  GNT;
  logic [0:7]  HEX0;
  logic [0:7]  HEX1;
  logic [0:7]  HEX2;
  logic [0:7]  HEX3;
  logic [0:7]  HEX4;
  logic [0:7]  HEX5;

  modport master (
    output REQ, ADV, DATA0, DATA1, DATA2,
    input  GNT, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );

  modport slave (
    input  REQ, ADV, DATA0, DATA1, DATA2,
    output GNT, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
endinterface

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing six 7-segment digits among three requesters.
// A grant is held for DWELL cycles unless dropped or advanced early.
module hex_display_arbiter #(
  parameter int DWELL = 50_000_000
) (
  input  logic CLOCK_50,
  input  logic RESET,
  hex_display_arbiter_if.slave bus
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DWELL - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t      state_q, state_d;
  logic [0:2]  gnt_q, gnt_d;
  logic [1:0]  last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [0:7]  hex_q [6];
  logic [0:7]  hex_d [6];

  logic [2:0]  pick_any;
  logic [2:0]  pick_oth;
  logic [CW-1:0] cnt_inc;
  logic [0:23] sel;

  function automatic logic [1:0] rr_next(
    input logic [1:0] i
  );
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [0:2] onehot(
    input logic [1:0] i
  );
    logic [0:2] o;
    unique case (i)
      2'd0:    o = 3'b100;
      2'd1:    o = 3'b010;
      default: o = 3'b001;
    endcase
    return o;
  endfunction

  // {found, index}; the current owner is only eligible when incl is set
  function automatic logic [2:0] rr_pick(
    input logic [0:2] r,
    input logic [1:0] l,
    input logic       incl
  );
    logic [1:0] c1;
    logic [1:0] c2;
    logic [2:0] p;
    c1 = rr_next(l);
    c2 = rr_next(c1);
    p  = 3'b000;
    if (r[c1])
      p = {1'b1, c1};
    else if (r[c2])
      p = {1'b1, c2};
    else if (incl && r[l])
      p = {1'b1, l};
    return p;
  endfunction

  function automatic logic [0:7] seg(
    input logic [3:0] n
  );
    logic [0:7] s;
    unique case (n)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    pick_any = rr_pick(bus.REQ, last_q, 1'b1);
    pick_oth = rr_pick(bus.REQ, last_q, 1'b0);
    cnt_inc  = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (pick_any[2]) begin
          state_d = GRANT;
          gnt_d   = onehot(pick_any[1:0]);
          last_d  = pick_any[1:0];
          cnt_d   = '0;
        end
      end
      default: begin
        // last_q always names the current owner while granted
        if (!bus.REQ[last_q]) begin
          if (pick_oth[2]) begin
            gnt_d  = onehot(pick_oth[1:0]);
            last_d = pick_oth[1:0];
            cnt_d  = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = 3'b000;
            cnt_d   = '0;
          end
        end else if ((cnt_q == CMAX || bus.ADV)
                     && pick_oth[2]) begin
          gnt_d  = onehot(pick_oth[1:0]);
          last_d = pick_oth[1:0];
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase
  end

  always_comb begin
    sel = bus.DATA0;
    unique case (1'b1)
      gnt_q[0]: sel = bus.DATA0;
      gnt_q[1]: sel = bus.DATA1;
      gnt_q[2]: sel = bus.DATA2;
      default:  sel = bus.DATA0;
    endcase
    for (int k = 0; k < 6; k++) begin
      hex_d[k] = (state_q == GRANT)
                 ? seg(sel[4*k +: 4])
                 : 8'hBF;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= IDLE;
      gnt_q   <= 3'b000;
      last_q  <= 2'd2;
      cnt_q   <= '0;
      for (int k = 0; k < 6; k++)
        hex_q[k] <= 8'hFF;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < 6; k++)
        hex_q[k] <= hex_d[k];
    end
  end

  assign bus.GNT  = gnt_q;
  assign bus.HEX0 = hex_q[0];
  assign bus.HEX1 = hex_q[1];
  assign bus.HEX2 = hex_q[2];
  assign bus.HEX3 = hex_q[3];
  assign bus.HEX4 = hex_q[4];
  assign bus.HEX5 = hex_q[5];

endmodule

// File: doc/hex_display_arbiter.md
HEX_DISPLAY_ARBITER -- requirements
Module: hex_display_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameter DWELL, default 50_000_000, meaning the minimum grant hold in clock cycles (legal range >= 2).
REQ-003 Port: CLOCK_50  input  1  system clock; every register updates on its rising edge.
REQ-004 Port: RESET  input  1  synchronous reset, active-high.
REQ-005 Port: REQ  input  [0:2]  display request; REQ[n] belongs to requester n.
REQ-006 Port: ADV  input  1  one-cycle pulse that forces early rotation.
REQ-007 Port: DATA0, DATA1, DATA2  input  [0:23] each  six hex nibbles; HEXk shows DATAn[4k..4k+3], with bit 4k as the nibble MSB.
REQ-008 Port: GNT  output  [0:2]  registered grant, either one-hot or all zero.
REQ-009 Port: HEX0..HEX5  output  [0:7] each  active-low segments; index 0=DP, 1=g, 2=f, 3=e, 4=d, 5=c, 6=b, 7=a.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE (no grant) and GRANT (one requester owns the display).
REQ-011 Arbitration SHALL be round-robin from pointer LAST, searching in the order LAST+1, LAST+2, LAST (mod 3).
REQ-012 In IDLE, if any REQ bit is set, the block SHALL enter GRANT with the first requester in round-robin order and GNT valid on the next edge.
REQ-013 On entry to GRANT, DWELL_CNT SHALL clear to 0 and LAST SHALL be set to the granted index.
REQ-014 In GRANT, DWELL_CNT SHALL increment by 1 per cycle and saturate at DWELL-1, with width ceil(log2(DWELL)).
REQ-015 In GRANT, if REQ[g] is 0, the block SHALL hand over on the next edge to the next other requester in round-robin order, or go to IDLE if none; this takes priority over REQ-016 and REQ-017.
REQ-016 In GRANT, if REQ[g] is 1 and DWELL_CNT equals DWELL-1 or ADV is 1, the block SHALL rotate to the next other pending requester on the next edge.
REQ-017 If the condition in REQ-016 holds but no other requester is pending, the block SHALL keep the grant, keep the counter saturated, and ignore ADV.
REQ-018 With the counter saturated, a newly asserted competing REQ SHALL cause rotation on the next edge.
REQ-019 Handover SHALL be gapless: GNT goes directly from one-hot to one-hot with no zero cycle, and never has two bits set.
REQ-020 ADV in IDLE SHALL have no effect.
REQ-021 In GRANT, each HEXk SHALL register decode(DATAg nibble k), where g is the currently registered grant; HEX therefore lags GNT by one cycle.
REQ-022 In IDLE, all HEXk SHALL register 8'hBF (dash).
REQ-023 The decode table SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
REQ-024 DP SHALL always be off (index 0 = 1) on every HEX output.

Reset
REQ-025 While RESET is 1 on an edge, the block SHALL set state IDLE, GNT=000, DWELL_CNT=0, LAST=2, and all HEXk=8'hFF (blank), regardless of REQ and ADV.
REQ-026 Reset asserted mid-GRANT SHALL take effect on that same edge, and arbitration SHALL restart with requester 0 at top priority.
REQ-027 On the first edge after RESET falls, the block SHALL evaluate REQ as in IDLE and show dashes if REQ=000.

Verification
REQ-028 The bench SHALL cover these directed scenarios with DWELL=4:
- Reset: RESET=1 for 2 cycles with REQ=111 -> GNT=000, HEX*=FF; 1 cycle after release GNT=100; next cycle HEX reflects DATA0.
- Single requester: REQ=100, DATA0 nibbles 0,1,2,3,4,5 (bit 0 first) -> GNT=100; HEX0..HEX5 = C0,F9,A4,B0,99,92; held indefinitely with no rotation.
- Full rotation: REQ=111 held -> GNT 100 for 4 cycles, 010 for 4, 001 for 4, then 100; never 000 or multi-hot.
- Drop: REQ=110, grant on 0, REQ[0] drops at count 1 -> GNT=010 next edge with count 0; drop all -> IDLE, HEX*=BF one cycle after GNT=000.
- ADV: grant 0 with REQ=101, ADV at count 0 -> GNT=001 next edge; ADV with REQ=100 -> no change.
- Reset mid-GRANT at count 2 with REQ=011 -> GNT=000, HEX*=FF on that edge; after release GNT=010.
